boot_rom_ctrl: RTL and testbench
================================

# boot_rom_ctrl

Parametrised boot instruction memory with a self-initialising fill sequencer, a request/valid read port and a boot-to-main-memory handover lock. It sits on the instruction-fetch path ahead of main memory. It supplies the BIOS image that copies the OS and the file table from the HD into memory, then locks itself once the CPU signals handover.

## Interface
- DATA_W, 32, instruction word width
- ADDR_W, 11, read address width
- DEPTH, 1131, number of ROM entries; must be ≤ 2^ADDR_W
- IMG_LEN, 44, number of programmed image words; entries IMG_LEN..DEPTH-1 hold NOOP (all zeros)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; clock clock
- rd_req  in  1  read request, sampled every edge
- rd_addr  in  ADDR_W  read address, sampled with rd_req
- rd_data  out  DATA_W  read data, valid with rd_valid
- rd_valid  out  1  one-cycle pulse per accepted request
- rd_err  out  1  qualifies rd_valid: address out of range or ROM locked
- ready  out  1  fill complete, reads accepted
- boot_mode  out  1  1 until handover is taken
- handover  in  1  single-cycle pulse from the CMB instruction decode

## Operation
- States: FILL, READY, LOCKED.
- Reset low at an edge forces the following on that edge:
  - state=FILL, fill_ptr=0
  - rd_data=0, rd_valid=0, rd_err=0, ready=0, boot_mode=1
- FILL:
  - Each edge writes mem[fill_ptr] = image(fill_ptr) and increments fill_ptr. image() returns the fixed BIOS word for indices below IMG_LEN and 0 otherwise.
  - When fill_ptr=DEPTH-1 is written, the block enters READY and ready=1.
  - rd_req and handover are ignored: no rd_valid, no error.
- READY:
  - rd_req=1 is accepted every cycle; back-to-back requests are allowed.
  - If rd_addr<DEPTH: rd_data=mem[rd_addr], rd_err=0.
  - Otherwise: rd_data=0, rd_err=1.
- handover=1 in READY moves the block to LOCKED and sets boot_mode=0 on that edge.
  - A rd_req accepted on the same edge still returns real data.
- LOCKED:
  - Every rd_req returns rd_data=0, rd_err=1.
  - ready stays 1.
  - Only reset leaves LOCKED.
- Reset mid-FILL or mid-read: the sequence restarts from fill_ptr=0 and any pending rd_valid is dropped.
- When rd_valid=0, rd_data holds its last value and rd_err=0.

## Timing
- Fill: the first edge with reset=1 writes entry 0. ready rises after edge DEPTH (1131 with defaults) and holds until reset.
- Read latency: 1 cycle. A request sampled at edge N gives rd_valid, rd_data and rd_err registered at N and visible until edge N+1.
- Throughput: one read per cycle.
- handover takes effect on the edge where it is sampled. A read on the next edge sees LOCKED.

## Configuration
- BOOT_ROM_PATCH_EN defined adds three ports:
  - wr_en  in  1
  - wr_addr  in  ADDR_W
  - wr_data  in  DATA_W
- Patch write behaviour:
  - In READY, wr_en=1 with wr_addr<DEPTH writes mem[wr_addr] on the edge.
  - Writes in FILL or LOCKED, and out-of-range writes, are ignored.
  - A read and a write to the same address on the same edge return the old data.
- Undefined: the ports are absent and the ROM is read-only after fill.

## Test plan
- Reset for 3 cycles, then release → ready=0 for 1131 edges, ready=1 after edge 1131; rd_valid stays 0 during FILL despite rd_req=1.
- After ready, read addr 0, 1, 43 back-to-back → one cycle later each: 0x6C000000, 0x08010002, 0x94000000 with rd_err=0; three consecutive rd_valid pulses.
- Read addr 500 → 0x00000000 (NOOP), rd_err=0. Read addr 1500 → rd_data=0, rd_err=1.
- rd_req at addr 1 together with handover → rd_data=0x08010002, rd_err=0, boot_mode=0. Next read at addr 0 → rd_data=0, rd_err=1.
- Reset pulse at fill edge 600 → ready=0, boot_mode=1; a full 1131-edge fill follows before ready=1.
- BOOT_ROM_PATCH_EN: write 0xDEADBEEF to addr 10 while reading addr 10 on the same edge → read returns 0x6C010000. Next read returns 0xDEADBEEF. A write after handover has no effect, confirmed after reset and refill.

Source files
------------

// File: rtl/boot_rom_ctrl_if.sv
// Instruction-fetch side bus of the boot ROM: read port, status and handover.
// BOOT_ROM_PATCH_EN adds the patch write port.
interface boot_rom_ctrl_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 11
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_err;
   logic              ready;
   logic              boot_mode;
   logic              handover;
`ifdef BOOT_ROM_PATCH_EN
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output rd_req, rd_addr, handover, wr_en, wr_addr, wr_data,
      input  rd_data, rd_valid, rd_err, ready, boot_mode
   );
   modport slave (
      input  rd_req, rd_addr, handover, wr_en, wr_addr, wr_data,
      output rd_data, rd_valid, rd_err, ready, boot_mode
   );
`else
   modport master (
      output rd_req, rd_addr, handover,
      input  rd_data, rd_valid, rd_err, ready, boot_mode
   );
   modport slave (
      input  rd_req, rd_addr, handover,
      output rd_data, rd_valid, rd_err, ready, boot_mode
   );
`endif
endinterface

// File: rtl/boot_rom_ctrl.sv
// Boot instruction ROM: self-fill from the BIOS image, 1-cycle read port, locks on handover.
// Optional patch write port enabled by defining BOOT_ROM_PATCH_EN.
module boot_rom_ctrl #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned DEPTH   = 1131,
   parameter int unsigned IMG_LEN = 44
) (
   input  logic            clock,
   input  logic            reset,
   boot_rom_ctrl_if.slave  bus
);

   localparam logic [1:0] StFill   = 2'd0;
   localparam logic [1:0] StReady  = 2'd1;
   localparam logic [1:0] StLocked = 2'd2;

   localparam int unsigned ImgWords = 44;

   // BIOS: copy OS and file table from HD into main memory, then hand over.
   localparam logic [31:0] BiosImage [ImgWords] = '{
      32'h6C000000, 32'h08010002, 32'h08020100, 32'h08030000,
      32'h1C000000, 32'h2C640001, 32'h50230001, 32'h58430004,
      32'h44000005, 32'h08010003, 32'h6C010000, 32'h08020200,
      32'h08030000, 32'h1C000000, 32'h2C640001, 32'h50230001,
      32'h58430004, 32'h4400000E, 32'h08040000, 32'h08050020,
      32'h8C840000, 32'h20A50001, 32'h48A0FFFE, 32'h08060400,
      32'h08070010, 32'h8CC60000, 32'h20E70001, 32'h48E0FFFE,
      32'h6C020000, 32'h08010004, 32'h08020300, 32'h1C000000,
      32'h2C640001, 32'h50230001, 32'h58430004, 32'h4400001F,
      32'h08080000, 32'h08090001, 32'h3C890000, 32'h6C030000,
      32'h08010000, 32'h08020000, 32'h04000000, 32'h94000000
   };

   function automatic logic [DATA_W-1:0] image_word(input logic [ADDR_W-1:0] idx);
      logic [DATA_W-1:0] w;
      w = '0;
      if (32'(idx) < IMG_LEN && 32'(idx) < ImgWords) begin
         w = DATA_W'(BiosImage[idx[5:0]]);
      end
      return w;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] fill_ptr_q, fill_ptr_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_err_q, rd_err_d;
   logic              ready_q, ready_d;
   logic              boot_mode_q, boot_mode_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic              rd_in_range;
   assign rd_in_range = 32'(bus.rd_addr) < DEPTH;

   always_comb begin
      state_d     = state_q;
      fill_ptr_d  = fill_ptr_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      rd_err_d    = 1'b0;
      ready_d     = ready_q;
      boot_mode_d = boot_mode_q;
      mem_we      = 1'b0;
      mem_waddr   = fill_ptr_q;
      mem_wdata   = image_word(fill_ptr_q);

      case (state_q)
         StFill: begin
            mem_we     = 1'b1;
            fill_ptr_d = fill_ptr_q + 1'b1;
            if (32'(fill_ptr_q) == DEPTH - 1) begin
               state_d = StReady;
               ready_d = 1'b1;
            end
         end
         StReady: begin
            if (bus.rd_req) begin
               rd_valid_d = 1'b1;
               if (rd_in_range) begin
                  rd_data_d = mem_q[bus.rd_addr];
               end else begin
                  rd_data_d = '0;
                  rd_err_d  = 1'b1;
               end
            end
`ifdef BOOT_ROM_PATCH_EN
            // Registered read above sees the pre-write contents on a same-edge collision.
            if (bus.wr_en && 32'(bus.wr_addr) < DEPTH) begin
               mem_we    = 1'b1;
               mem_waddr = bus.wr_addr;
               mem_wdata = bus.wr_data;
            end
`endif
            if (bus.handover) begin
               state_d     = StLocked;
               boot_mode_d = 1'b0;
            end
         end
         StLocked: begin
            if (bus.rd_req) begin
               rd_valid_d = 1'b1;
               rd_data_d  = '0;
               rd_err_d   = 1'b1;
            end
         end
         default: begin
            state_d    = StFill;
            fill_ptr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= StFill;
         fill_ptr_q  <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_err_q    <= 1'b0;
         ready_q     <= 1'b0;
         boot_mode_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         fill_ptr_q  <= fill_ptr_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         rd_err_q    <= rd_err_d;
         ready_q     <= ready_d;
         boot_mode_q <= boot_mode_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_err    = rd_err_q;
   assign bus.ready     = ready_q;
   assign bus.boot_mode = boot_mode_q;

endmodule

// File: tb/tb_boot_rom_ctrl.sv
// Self-checking bench for boot_rom_ctrl: directed steps plus randomized reads against a
// behavioural ROM model (expected contents, lock flag, last returned word).
module tb_boot_rom_ctrl;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 11;
   localparam int unsigned DEPTH   = 1131;
   localparam int unsigned IMG_LEN = 44;

   localparam logic [31:0] IMG [44] = '{
      32'h6C000000, 32'h08010002, 32'h08020100, 32'h08030000,
      32'h1C000000, 32'h2C640001, 32'h50230001, 32'h58430004,
      32'h44000005, 32'h08010003, 32'h6C010000, 32'h08020200,
      32'h08030000, 32'h1C000000, 32'h2C640001, 32'h50230001,
      32'h58430004, 32'h4400000E, 32'h08040000, 32'h08050020,
      32'h8C840000, 32'h20A50001, 32'h48A0FFFE, 32'h08060400,
      32'h08070010, 32'h8CC60000, 32'h20E70001, 32'h48E0FFFE,
      32'h6C020000, 32'h08010004, 32'h08020300, 32'h1C000000,
      32'h2C640001, 32'h50230001, 32'h58430004, 32'h4400001F,
      32'h08080000, 32'h08090001, 32'h3C890000, 32'h6C030000,
      32'h08010000, 32'h08020000, 32'h04000000, 32'h94000000
   };

   logic clock;
   logic reset;

   boot_rom_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

   boot_rom_ctrl #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .IMG_LEN(IMG_LEN)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bif.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_mem [DEPTH];
   bit          locked;
   logic [31:0] exp_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(DEPTH); i++) begin
         model_mem[i] = (i < int'(IMG_LEN)) ? IMG[i] : 32'h0;
      end
      locked   = 1'b0;
      exp_data = 32'h0;
   endtask

   // One accepted read; leaves rd_req asserted so calls chain back-to-back.
   task automatic read1(input string tag, input int addr, input logic [31:0] d, input logic e);
      bif.rd_req  = 1'b1;
      bif.rd_addr = ADDR_W'(addr);
      step();
      chk1({tag, "_valid"}, bif.rd_valid, 1'b1);
      chk({tag, "_data"}, bif.rd_data, d);
      chk1({tag, "_err"}, bif.rd_err, e);
      exp_data = d;
   endtask

   task automatic rand_cycle();
      bit          req;
      logic [10:0] a;
      logic [31:0] d;
      logic        e;
`ifdef BOOT_ROM_PATCH_EN
      bit          we;
      logic [10:0] wa;
      logic [31:0] wd;
`endif
      req = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) a = 11'($urandom_range(DEPTH, 2047));
      else                           a = 11'($urandom_range(0, DEPTH - 1));
      bif.rd_req  = req;
      bif.rd_addr = a;
`ifdef BOOT_ROM_PATCH_EN
      we = ($urandom_range(0, 2) == 0);
      wa = (req && $urandom_range(0, 3) == 0) ? a : 11'($urandom_range(64, 2047));
      if (wa < 64) wa = 11'd64;
      wd = $urandom();
      bif.wr_en   = we;
      bif.wr_addr = wa;
      bif.wr_data = wd;
`endif
      step();
      if (req) begin
         if (locked || a >= DEPTH) begin
            d = 32'h0;
            e = 1'b1;
         end else begin
            d = model_mem[a];
            e = 1'b0;
         end
         exp_data = d;
      end else begin
         e = 1'b0;
      end
      chk1("rand_valid", bif.rd_valid, req);
      chk1("rand_err", bif.rd_err, e);
      chk("rand_data", bif.rd_data, exp_data);
`ifdef BOOT_ROM_PATCH_EN
      if (we && !locked && wa < DEPTH) model_mem[wa] = wd;
      bif.wr_en = 1'b0;
`endif
      bif.rd_req = 1'b0;
   endtask

   initial begin
      int n;
      reset        = 1'b0;
      bif.rd_req   = 1'b0;
      bif.rd_addr  = '0;
      bif.handover = 1'b0;
`ifdef BOOT_ROM_PATCH_EN
      bif.wr_en    = 1'b0;
      bif.wr_addr  = '0;
      bif.wr_data  = '0;
`endif
      model_reset();

      repeat (3) step();
      chk1("rst_ready", bif.ready, 1'b0);
      chk1("rst_boot_mode", bif.boot_mode, 1'b1);
      chk1("rst_valid", bif.rd_valid, 1'b0);
      chk1("rst_err", bif.rd_err, 1'b0);
      chk("rst_data", bif.rd_data, 32'h0);

      // Fill: reads and handover must be ignored throughout
      reset = 1'b1;
      for (int e = 1; e <= int'(DEPTH); e++) begin
         bif.rd_req   = 1'($urandom_range(0, 1));
         bif.rd_addr  = 11'($urandom_range(0, 2047));
         bif.handover = 1'($urandom_range(0, 1));
         step();
         chk1("fill_ready", bif.ready, e == int'(DEPTH));
         chk1("fill_valid", bif.rd_valid, 1'b0);
      end
      bif.handover = 1'b0;
      bif.rd_req   = 1'b0;
      chk1("fill_boot_mode", bif.boot_mode, 1'b1);
      chk("fill_data", bif.rd_data, 32'h0);

      read1("rd0", 0, 32'h6C000000, 1'b0);
      read1("rd1", 1, 32'h08010002, 1'b0);
      read1("rd43", 43, 32'h94000000, 1'b0);
      bif.rd_req = 1'b0;
      step();
      chk1("idle_valid", bif.rd_valid, 1'b0);
      chk1("idle_err", bif.rd_err, 1'b0);
      chk("idle_hold", bif.rd_data, 32'h94000000);

      read1("rd500", 500, 32'h0, 1'b0);
      read1("rd1500", 1500, 32'h0, 1'b1);
      bif.rd_req = 1'b0;
      step();
      chk1("idle2_err", bif.rd_err, 1'b0);

`ifdef BOOT_ROM_PATCH_EN
      bif.wr_en   = 1'b1;
      bif.wr_addr = 11'd10;
      bif.wr_data = 32'hDEADBEEF;
      read1("patch_old", 10, 32'h6C010000, 1'b0);
      bif.wr_en     = 1'b0;
      model_mem[10] = 32'hDEADBEEF;
      read1("patch_new", 10, 32'hDEADBEEF, 1'b0);
      bif.rd_req = 1'b0;
`endif

      repeat (300) rand_cycle();

      // Handover with a same-edge read still returns real data
      bif.rd_req   = 1'b1;
      bif.rd_addr  = 11'd1;
      bif.handover = 1'b1;
      step();
      bif.handover = 1'b0;
      chk1("ho_valid", bif.rd_valid, 1'b1);
      chk("ho_data", bif.rd_data, 32'h08010002);
      chk1("ho_err", bif.rd_err, 1'b0);
      chk1("ho_boot_mode", bif.boot_mode, 1'b0);
      locked = 1'b1;
      read1("locked_rd0", 0, 32'h0, 1'b1);
      bif.rd_req = 1'b0;
      chk1("locked_ready", bif.ready, 1'b1);

`ifdef BOOT_ROM_PATCH_EN
      bif.wr_en   = 1'b1;
      bif.wr_addr = 11'd10;
      bif.wr_data = 32'h12345678;
      step();
      bif.wr_en = 1'b0;
`endif
      repeat (100) rand_cycle();
      chk1("locked_boot_mode", bif.boot_mode, 1'b0);

      // Reset during a read drops the pending response
      bif.rd_req  = 1'b1;
      bif.rd_addr = 11'd2;
      reset = 1'b0;
      step();
      chk1("rrd_valid", bif.rd_valid, 1'b0);
      chk1("rrd_ready", bif.ready, 1'b0);
      chk1("rrd_boot_mode", bif.boot_mode, 1'b1);
      chk("rrd_data", bif.rd_data, 32'h0);
      bif.rd_req = 1'b0;
      reset = 1'b1;

      // Reset at fill edge 600 restarts the whole fill
      repeat (599) step();
      chk1("mid_fill_ready", bif.ready, 1'b0);
      reset = 1'b0;
      bif.rd_req = 1'b1;
      step();
      chk1("r600_ready", bif.ready, 1'b0);
      chk1("r600_boot_mode", bif.boot_mode, 1'b1);
      chk1("r600_valid", bif.rd_valid, 1'b0);
      reset = 1'b1;
      bif.rd_req = 1'b0;
      n = 0;
      while (!bif.ready && n < int'(DEPTH) + 10) begin
         step();
         n++;
      end
      chk("refill_edges", 32'(n), DEPTH);

      model_reset();
      read1("refill_rd10", 10, 32'h6C010000, 1'b0);
      read1("refill_rd0", 0, 32'h6C000000, 1'b0);
      read1("refill_rd43", 43, 32'h94000000, 1'b0);
      bif.rd_req = 1'b0;
      chk1("refill_boot_mode", bif.boot_mode, 1'b1);
      repeat (200) rand_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
